// File: rtl/cpu_seq_pkg.sv
// ============================================================================
// cpu_seq_pkg : shared encodings for the EIP update sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_seq_pkg;

   localparam logic [2:0] BR_SEQ     = 3'd0;
   localparam logic [2:0] BR_JMP_ABS = 3'd1;
   localparam logic [2:0] BR_JMP_REL = 3'd2;
   localparam logic [2:0] BR_CALL    = 3'd3;
   localparam logic [2:0] BR_RET     = 3'd4;
   localparam logic [2:0] BR_HALT    = 3'd5;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_UPDATE = 2'd1,
      ST_HALT   = 2'd2,
      ST_FAULT  = 2'd3
   } seq_state_t;

   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_BAD     = 2'd1;
   localparam logic [1:0] FC_RAS_OVF = 2'd2;
   localparam logic [1:0] FC_RAS_UNF = 2'd3;

   localparam logic [31:0] DEFAULT_RESET_EIP = 32'h0000_0041;

   // Length or type outside the legal encoding space.
   function automatic logic instr_illegal(input logic [3:0] len,
                                          input logic [2:0] kind,
                                          input logic [3:0] max_len);
      return (len == 4'd0) || (len > max_len) || (kind > BR_HALT);
   endfunction

endpackage

`default_nettype wire

// File: rtl/eip_ras.sv
// ============================================================================
// eip_ras : RAS_DEPTH x 32 return-address LIFO; only the pointer is reset
// Rev 1.0
// ============================================================================
`default_nettype none

module eip_ras #(
   parameter int RAS_DEPTH = 4
) (
   input  logic        clock_12,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] push_data,
   output logic [31:0] pop_data,
   output logic        full,
   output logic        empty
);

   localparam int AW = $clog2(RAS_DEPTH);

   logic [31:0] mem [RAS_DEPTH];
   logic [AW:0] sp;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign full   = (sp == (AW+1)'(RAS_DEPTH));
   assign empty  = (sp == '0);
   assign wr_ptr = sp[AW-1:0];
   assign rd_ptr = sp[AW-1:0] - AW'(1);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clock_12) begin
      if (reset) begin
         sp <= '0;
      end else if (push && !full) begin
         sp <= sp + (AW+1)'(1);
      end else if (pop && !empty) begin
         sp <= sp - (AW+1)'(1);
      end
   end

   // Storage is deliberately left unreset; a stale entry is unreachable once sp is cleared.
   always_ff @(posedge clock_12) begin
      if (!reset && push && !full) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/eip_update_sequencer.sv
// ============================================================================
// eip_update_sequencer : architectural EIP sequencing (seq/jmp/call/ret/halt)
// Rev 1.0
// ============================================================================
`default_nettype none

module eip_update_sequencer
   import cpu_seq_pkg::*;
#(
   parameter logic [31:0] RESET_EIP = DEFAULT_RESET_EIP,
   parameter int          RAS_DEPTH = 4,
   parameter int          MAX_OPE   = 6
) (
   input  logic        clock_12,
   input  logic        reset,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [3:0]  num_of_ope,
   input  logic [2:0]  br_type,
   input  logic [31:0] br_target,
   output logic [31:0] eip,
   output logic        eip_valid,
   output logic        halted,
   output logic        fault,
   output logic [1:0]  fault_code
);

   localparam logic [3:0] MAX_LEN = 4'(MAX_OPE);

   seq_state_t  state, state_n;
   logic [31:0] eip_n;
   logic [1:0]  fault_code_n;
   logic        capture;
   logic [3:0]  cap_len;
   logic [2:0]  cap_type;
   logic [31:0] cap_target;
   logic [31:0] seq_eip;
   logic        ras_push, ras_pop, ras_full, ras_empty;
   logic [31:0] ras_pop_data;

   eip_ras #(
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clock_12  (clock_12),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (seq_eip),
      .pop_data  (ras_pop_data),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   assign seq_eip = eip + {28'd0, cap_len};

   always_ff @(posedge clock_12) begin
      if (reset) begin
         state      <= ST_RUN;
         eip        <= RESET_EIP;
         fault_code <= FC_NONE;
         cap_len    <= '0;
         cap_type   <= '0;
         cap_target <= '0;
      end else begin
         state      <= state_n;
         eip        <= eip_n;
         fault_code <= fault_code_n;
         if (capture) begin
            cap_len    <= num_of_ope;
            cap_type   <= br_type;
            cap_target <= br_target;
         end
      end
   end

   always_comb begin
      state_n      = state;
      eip_n        = eip;
      fault_code_n = fault_code;
      capture      = 1'b0;
      ras_push     = 1'b0;
      ras_pop      = 1'b0;
      unique case (state)
         ST_RUN: begin
            if (instr_valid) begin
               capture = 1'b1;
               state_n = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            state_n = ST_RUN;
            if (instr_illegal(cap_len, cap_type, MAX_LEN)) begin
               fault_code_n = FC_BAD;
               state_n      = ST_FAULT;
            end else begin
               case (cap_type)
                  BR_SEQ:     eip_n = seq_eip;
                  BR_JMP_ABS: eip_n = cap_target;
                  BR_JMP_REL: eip_n = seq_eip + cap_target;
                  BR_CALL: begin
                     if (ras_full) begin
                        fault_code_n = FC_RAS_OVF;
                        state_n      = ST_FAULT;
                     end else begin
                        ras_push = 1'b1;
                        eip_n    = cap_target;
                     end
                  end
                  BR_RET: begin
                     if (ras_empty) begin
                        fault_code_n = FC_RAS_UNF;
                        state_n      = ST_FAULT;
                     end else begin
                        ras_pop = 1'b1;
                        eip_n   = ras_pop_data;
                     end
                  end
                  BR_HALT: begin
                     eip_n   = seq_eip;
                     state_n = ST_HALT;
                  end
                  default: begin
                     fault_code_n = FC_BAD;
                     state_n      = ST_FAULT;
                  end
               endcase
            end
         end
         ST_HALT:  state_n = ST_HALT;
         ST_FAULT: state_n = ST_FAULT;
         default:  state_n = ST_FAULT;
      endcase
   end

   assign instr_ready = (state == ST_RUN);
   assign eip_valid   = (state == ST_RUN) || (state == ST_HALT);
   assign halted      = (state == ST_HALT);
   assign fault       = (state == ST_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_eip_update_sequencer.sv
// ============================================================================
// tb_eip_update_sequencer : directed + random bench against a queue-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_eip_update_sequencer;

   logic        clock_12 = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [3:0]  num_of_ope = '0;
   logic [2:0]  br_type = '0;
   logic [31:0] br_target = '0;
   logic [31:0] eip;
   logic        eip_valid, halted, fault;
   logic [1:0]  fault_code;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [31:0] m_eip;
   logic [31:0] m_ras[$];
   bit          m_halted, m_fault;
   logic [1:0]  m_fc;

   always #5 clock_12 = ~clock_12;

   eip_update_sequencer dut (
      .clock_12    (clock_12),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .num_of_ope  (num_of_ope),
      .br_type     (br_type),
      .br_target   (br_target),
      .eip         (eip),
      .eip_valid   (eip_valid),
      .halted      (halted),
      .fault       (fault),
      .fault_code  (fault_code)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] dut_status();
      return {26'd0, instr_ready, eip_valid, halted, fault, fault_code};
   endfunction

   function automatic logic [31:0] model_status();
      logic rdy, vld;
      rdy = !(m_halted || m_fault);
      vld = !m_fault;
      return {26'd0, rdy, vld, m_halted, m_fault, m_fc};
   endfunction

   task automatic model_apply(input logic [3:0] len, input logic [2:0] ty, input logic [31:0] tgt);
      logic [31:0] nxt;
      nxt = m_eip + 32'(len);
      if (len == 0 || len > 6 || ty > 5) begin
         m_fault = 1; m_fc = 2'd1;
      end else begin
         case (ty)
            3'd0: m_eip = nxt;
            3'd1: m_eip = tgt;
            3'd2: m_eip = nxt + tgt;
            3'd3: if (m_ras.size() >= 4) begin m_fault = 1; m_fc = 2'd2; end
                  else begin m_ras.push_back(nxt); m_eip = tgt; end
            3'd4: if (m_ras.size() == 0) begin m_fault = 1; m_fc = 2'd3; end
                  else m_eip = m_ras.pop_back();
            default: begin m_eip = nxt; m_halted = 1; end
         endcase
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      instr_valid = 1'b0;
      @(posedge clock_12); #1;
      reset = 1'b0;
      m_eip = 32'h41; m_ras.delete(); m_halted = 0; m_fault = 0; m_fc = 2'd0;
      check("reset_eip", eip, m_eip);
      check("reset_status", dut_status(), model_status());
   endtask

   task automatic issue(input logic [3:0] len, input logic [2:0] ty, input logic [31:0] tgt);
      check("ready_pre", {31'd0, instr_ready}, 32'd1);
      instr_valid = 1'b1; num_of_ope = len; br_type = ty; br_target = tgt;
      @(posedge clock_12); #1;
      instr_valid = 1'b0;
      num_of_ope = 4'($urandom); br_type = 3'($urandom); br_target = $urandom;
      check("upd_status", dut_status(), 32'd0);
      check("upd_eip", eip, m_eip);
      model_apply(len, ty, tgt);
      @(posedge clock_12); #1;
      check("eip", eip, m_eip);
      check("status", dut_status(), model_status());
   endtask

   // Decoder keeps presenting while the sequencer is stopped; nothing may change.
   task automatic hold_valid(input int cycles);
      instr_valid = 1'b1; num_of_ope = 4'd1; br_type = 3'd0;
      repeat (cycles) @(posedge clock_12);
      #1;
      instr_valid = 1'b0;
      check("hold_eip", eip, m_eip);
      check("hold_status", dut_status(), model_status());
   endtask

   initial begin
      do_reset();

      // Sequential advance, back-to-back acceptance, relative jump backwards
      issue(4'd3, 3'd0, 32'h0);
      issue(4'd2, 3'd2, 32'hFFFF_FFF0);
      check("jrel_abs", eip, 32'h36);
      issue(4'd1, 3'd1, 32'hFFFF_FFFE);
      issue(4'd3, 3'd0, 32'h0);
      check("wrap", eip, 32'h1);

      // Call / return pair then underflow
      do_reset();
      issue(4'd5, 3'd3, 32'h100);
      check("call_tgt", eip, 32'h100);
      issue(4'd1, 3'd4, 32'h0);
      check("ret_val", eip, 32'h46);
      issue(4'd1, 3'd4, 32'h0);
      check("unf_code", {30'd0, fault_code}, 32'd3);
      hold_valid(3);

      // RAS overflow on fifth call
      do_reset();
      for (int i = 1; i <= 5; i++) issue(4'd2, 3'd3, 32'(i) << 8);
      check("ovf_code", {30'd0, fault_code}, 32'd2);
      check("ovf_eip", eip, 32'h400);

      // Illegal length / type; length check also applies to ABS and RET
      do_reset(); issue(4'd0, 3'd0, 32'h0);
      do_reset(); issue(4'd7, 3'd0, 32'h0);
      do_reset(); issue(4'd1, 3'd6, 32'h0);
      do_reset(); issue(4'd0, 3'd1, 32'h500);
      do_reset(); issue(4'd6, 3'd3, 32'h80); issue(4'd9, 3'd4, 32'h0);

      // Reset during UPDATE discards the pending push
      do_reset();
      instr_valid = 1'b1; num_of_ope = 4'd2; br_type = 3'd3; br_target = 32'h700;
      @(posedge clock_12); #1;
      instr_valid = 1'b0;
      do_reset();
      issue(4'd1, 3'd4, 32'h0);

      // Halt holds until reset
      do_reset();
      issue(4'd2, 3'd5, 32'h0);
      check("halt_eip", eip, 32'h43);
      hold_valid(10);
      do_reset();

      // Randomized instruction streams
      for (int n = 0; n < 400; n++) begin
         logic [3:0] len;
         logic [2:0] ty;
         logic [31:0] tgt;
         if (m_halted || m_fault) begin
            hold_valid(int'($urandom_range(1, 4)));
            do_reset();
         end
         len = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'($urandom_range(1, 6));
         ty  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         tgt = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(8'($urandom)));
         issue(len, ty, tgt);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
